// File: rtl/imm_field_encoder_pkg.sv
// Shared encodings for the immediate field encoder: format codes (same as the
// sign extender's Ctrl input), error codes, FSM states and the pipeline word.
package imm_field_encoder_pkg;

  localparam logic [1:0] IMM_I   = 2'b00;
  localparam logic [1:0] IMM_D   = 2'b01;
  localparam logic [1:0] IMM_B   = 2'b10;
  localparam logic [1:0] IMM_CBZ = 2'b11;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  err_code;
  } enc_word_t;

  // True when bits [63:msb] are all equal, i.e. the value survives
  // truncation to msb+1 bits followed by sign extension.
  function automatic logic sext_fits(input logic signed [63:0] v,
                                     input int unsigned msb);
    logic signed [63:0] hi;
    hi = v >>> msb;
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/imm_field_encoder_pack_check.sv
// Combinational packer: inserts the immediate into the instruction template
// and flags range / alignment violations; an errored word returns the template.
module imm_field_encoder_pack_check
  import imm_field_encoder_pkg::*;
(
  input  logic [63:0] i_imm,
  input  logic [1:0]  i_ctrl,
  input  logic [31:0] i_base,
  output logic [31:0] o_instr,
  output logic [1:0]  o_err_code
);

  logic        w_range;
  logic        w_align;
  logic [31:0] w_instr;

  always_comb begin
    w_range = 1'b0;
    w_align = 1'b0;
    w_instr = i_base;
    case (i_ctrl)
      IMM_I: begin
        w_range        = |i_imm[63:12];
        w_instr[21:10] = i_imm[11:0];
      end
      IMM_D: begin
        w_range        = !sext_fits(i_imm, 8);
        w_instr[20:12] = i_imm[8:0];
      end
      IMM_B: begin
        w_range       = !sext_fits(i_imm, 27);
        w_align       = |i_imm[1:0];
        w_instr[25:0] = i_imm[27:2];
      end
      default: begin
        w_range       = !sext_fits(i_imm, 20);
        w_align       = |i_imm[1:0];
        w_instr[23:5] = i_imm[20:2];
      end
    endcase
    o_err_code = {w_align, w_range};
    o_instr    = (w_range || w_align) ? i_base : w_instr;
  end

endmodule

// File: rtl/imm_field_encoder.sv
// Two-stage valid/ready immediate encoder with saturating error counter and
// optional halt-after-error until clear_err.
module imm_field_encoder
  import imm_field_encoder_pkg::*;
#(
  parameter bit STOP_ON_ERR = 1'b0,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_imm,
  input  logic [1:0]       in_ctrl,
  input  logic [31:0]      in_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [1:0]       out_err_code,
  input  logic             clear_err,
  output logic             halted,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [31:0]      w_pack_instr;
  logic [1:0]       w_pack_code;
  logic             w_s1_move;
  logic             w_accept;
  logic             w_err_hs;

  logic             r_s1_valid;
  logic             r_s2_valid;
  enc_word_t        r_s1_word;
  enc_word_t        r_s2_word;
  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_err_cnt;

  imm_field_encoder_pack_check u_pack (
    .i_imm      (in_imm),
    .i_ctrl     (in_ctrl),
    .i_base     (in_base),
    .o_instr    (w_pack_instr),
    .o_err_code (w_pack_code)
  );

  assign w_s1_move = !r_s2_valid || out_ready;
  assign in_ready  = (r_state == ST_RUN) && (!r_s1_valid || w_s1_move);
  assign w_accept  = in_valid && in_ready;
  assign w_err_hs  = r_s2_valid && out_ready && (r_s2_word.err_code != ERR_OK);

  // S1 holds the packed word and its check result; S2 is the output register.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s1_word  <= '0;
      r_s2_word  <= '0;
    end else begin
      if (!r_s1_valid || w_s1_move) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1_word.instr    <= w_pack_instr;
          r_s1_word.err_code <= w_pack_code;
        end
      end
      if (w_s1_move) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_word <= r_s1_word;
        end
      end
    end
  end

  // An error handshake in the same cycle as clear_err takes precedence.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state   <= ST_RUN;
      r_err_cnt <= '0;
    end else begin
      if (STOP_ON_ERR && w_err_hs) begin
        r_state <= ST_HALT;
      end else if (clear_err) begin
        r_state <= ST_RUN;
      end
      if (w_err_hs) begin
        if (clear_err) begin
          r_err_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (r_err_cnt != CNT_MAX) begin
          r_err_cnt <= r_err_cnt + 1'b1;
        end
      end else if (clear_err) begin
        r_err_cnt <= '0;
      end
    end
  end

  assign out_valid    = r_s2_valid;
  assign out_instr    = r_s2_word.instr;
  assign out_err_code = r_s2_word.err_code;
  assign out_err      = (r_s2_word.err_code != ERR_OK);
  assign halted       = (r_state == ST_HALT);
  assign err_count    = r_err_cnt;

endmodule

// File: tb/tb_imm_field_encoder.sv
// Bench for imm_field_encoder: directed vectors, stall/order, halt-on-error,
// reset with words in flight, and a randomized stream against a reference model.
module tb_imm_field_encoder;

  logic        CLK = 1'b0;
  logic        Reset_L = 1'b0;
  logic        a_valid = 1'b0;
  logic        b_valid = 1'b0;
  logic        a_out_ready = 1'b0;
  logic        b_out_ready = 1'b0;
  logic        clear_err = 1'b0;
  logic [63:0] in_imm = '0;
  logic [1:0]  in_ctrl = '0;
  logic [31:0] in_base = '0;

  logic        a_in_ready, a_out_valid, a_out_err, a_halted;
  logic [31:0] a_out_instr;
  logic [1:0]  a_out_err_code;
  logic [2:0]  a_err_count;
  logic        b_in_ready, b_out_valid, b_out_err, b_halted;
  logic [31:0] b_out_instr;
  logic [1:0]  b_out_err_code;
  logic [15:0] b_err_count;

  int checks = 0;
  int failures = 0;

  logic [33:0] exp_q[$];
  logic [63:0] imm_q[$];
  logic [1:0]  ctrl_q[$];

  imm_field_encoder #(.STOP_ON_ERR(1'b0), .CNT_W(3)) dut_a (
    .CLK(CLK), .Reset_L(Reset_L), .in_valid(a_valid), .in_ready(a_in_ready),
    .in_imm(in_imm), .in_ctrl(in_ctrl), .in_base(in_base),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_instr(a_out_instr),
    .out_err(a_out_err), .out_err_code(a_out_err_code), .clear_err(clear_err),
    .halted(a_halted), .err_count(a_err_count));

  imm_field_encoder #(.STOP_ON_ERR(1'b1), .CNT_W(16)) dut_b (
    .CLK(CLK), .Reset_L(Reset_L), .in_valid(b_valid), .in_ready(b_in_ready),
    .in_imm(in_imm), .in_ctrl(in_ctrl), .in_base(in_base),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_instr(b_out_instr),
    .out_err(b_out_err), .out_err_code(b_out_err_code), .clear_err(clear_err),
    .halted(b_halted), .err_count(b_err_count));

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {err_code, instr} from the range rules as plain integer arithmetic.
  function automatic logic [33:0] model(input logic [1:0] c, input logic [63:0] imm,
                                        input logic [31:0] base);
    longint v;
    logic   rng, mis;
    logic [31:0] ins;
    v   = imm;
    mis = 1'b0;
    case (c)
      2'd0: begin
        rng = (imm >= 64'd4096);
        ins = (base & ~(32'hFFF << 10)) | (32'(imm % 64'd4096) << 10);
      end
      2'd1: begin
        rng = (v < -256) || (v > 255);
        ins = (base & ~(32'h1FF << 12)) | (32'(v & 511) << 12);
      end
      2'd2: begin
        rng = (v < -(64'sd1 << 27)) || (v > (64'sd1 << 27) - 1);
        mis = (v % 4) != 0;
        ins = (base & ~32'h3FFFFFF) | 32'((v / 4) & 64'h3FFFFFF);
      end
      default: begin
        rng = (v < -(64'sd1 << 20)) || (v > (64'sd1 << 20) - 1);
        mis = (v % 4) != 0;
        ins = (base & ~(32'h7FFFF << 5)) | (32'((v / 4) & 64'h7FFFF) << 5);
      end
    endcase
    if (rng || mis) ins = base;
    return {mis, rng, ins};
  endfunction

  // Sign-extender model: recovers the byte offset / immediate from a packed word.
  function automatic longint extend(input logic [31:0] ins, input logic [1:0] c);
    longint f;
    case (c)
      2'd0: f = longint'(ins[21:10]);
      2'd1: begin f = longint'(ins[20:12]); if (f > 255) f -= 512; end
      2'd2: begin f = longint'(ins[25:0]); if (f >= (64'sd1 << 25)) f -= (64'sd1 << 26); f *= 4; end
      default: begin f = longint'(ins[23:5]); if (f >= (64'sd1 << 18)) f -= (64'sd1 << 19); f *= 4; end
    endcase
    return f;
  endfunction

  function automatic logic [63:0] gen_imm(input logic [1:0] c, input int kind);
    longint lo, hi, r;
    longint step;
    case (c)
      2'd0: begin lo = 0; hi = 4095; step = 1; end
      2'd1: begin lo = -256; hi = 255; step = 1; end
      2'd2: begin lo = -(64'sd1 << 27); hi = (64'sd1 << 27) - 4; step = 4; end
      default: begin lo = -(64'sd1 << 20); hi = (64'sd1 << 20) - 4; step = 4; end
    endcase
    if (kind == 0) begin
      r = lo + longint'($urandom_range(0, 32'(hi - lo)));
      if (step == 4) r = r & ~64'sd3;
    end else if (kind == 1) begin
      r = {$urandom, $urandom};
    end else begin
      case ($urandom_range(0, 3))
        0: r = lo;
        1: r = hi;
        2: r = lo - step;
        default: r = hi + step;
      endcase
    end
    return 64'(r);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_a(input string tag, input logic [1:0] c, input logic [63:0] imm,
                        input logic [31:0] base, input logic [31:0] ei, input logic [1:0] ec);
    in_ctrl = c; in_imm = imm; in_base = base; a_valid = 1'b1; a_out_ready = 1'b1;
    @(negedge CLK);
    chk({tag, ".in_ready"}, a_in_ready, 1);
    tick();
    a_valid = 1'b0; in_imm = {$urandom, $urandom}; in_base = $urandom;
    @(negedge CLK);
    chk({tag, ".early"}, a_out_valid, 0);
    tick();
    @(negedge CLK);
    chk({tag, ".valid"}, a_out_valid, 1);
    chk({tag, ".instr"}, a_out_instr, ei);
    chk({tag, ".code"}, a_out_err_code, ec);
    chk({tag, ".err"}, a_out_err, ec != 2'b00);
    tick();
  endtask

  // mode 0: out_ready toggles 1,0,1,0..; mode 1: random out_ready.
  task automatic stream_a(input string tag, input int n, input int mode, input int vpct);
    int gen_n, sent, got, cyc, errs;
    logic acc, stall_prev;
    logic [31:0] held;
    logic [33:0] e;
    logic [63:0] eimm;
    logic [1:0]  ectrl;
    gen_n = 0; sent = 0; got = 0; cyc = 0; errs = 0; acc = 0; stall_prev = 0; held = '0;
    exp_q.delete(); imm_q.delete(); ctrl_q.delete();
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    while (got < n && cyc < n * 20 + 50) begin
      if (acc) a_valid = 1'b0;
      if (!a_valid && gen_n < n && $urandom_range(0, 99) < vpct) begin
        in_ctrl = 2'($urandom_range(0, 3));
        in_imm  = gen_imm(in_ctrl, ($urandom_range(0, 9) < 6) ? 0 : ($urandom_range(0, 1) ? 1 : 2));
        in_base = $urandom;
        a_valid = 1'b1;
        gen_n++;
      end
      a_out_ready = (mode == 0) ? (cyc % 2 == 0) : ($urandom_range(0, 99) < 70);
      @(negedge CLK);
      if (stall_prev) begin
        chk({tag, ".stall_valid"}, a_out_valid, 1);
        chk({tag, ".stall_instr"}, a_out_instr, held);
      end
      acc = a_valid && a_in_ready;
      if (acc) begin
        exp_q.push_back(model(in_ctrl, in_imm, in_base));
        imm_q.push_back(in_imm);
        ctrl_q.push_back(in_ctrl);
        sent++;
      end
      if (a_out_valid && a_out_ready) begin
        if (exp_q.size() == 0) begin
          chk({tag, ".unexpected_word"}, 1, 0);
        end else begin
          e = exp_q.pop_front(); eimm = imm_q.pop_front(); ectrl = ctrl_q.pop_front();
          chk({tag, ".instr"}, a_out_instr, e[31:0]);
          chk({tag, ".code"}, a_out_err_code, e[33:32]);
          if (e[33:32] == 2'b00) chk({tag, ".roundtrip"}, 64'(extend(a_out_instr, ectrl)), eimm);
          else errs++;
        end
        got++;
      end
      stall_prev = a_out_valid && !a_out_ready;
      held = a_out_instr;
      tick();
      cyc++;
    end
    a_valid = 1'b0;
    chk({tag, ".words_out"}, got, n);
    chk({tag, ".words_in"}, sent, n);
    chk({tag, ".err_count"}, a_err_count, (errs > 7) ? 7 : errs);
  endtask

  logic [1:0]  bw_ctrl[4];
  logic [63:0] bw_imm[4];
  logic [31:0] bw_base[4];

  task automatic run_b(input int cycles, inout int idx, inout int outn);
    logic [33:0] e;
    for (int k = 0; k < cycles; k++) begin
      b_valid = (idx < 4);
      if (idx < 4) begin in_ctrl = bw_ctrl[idx]; in_imm = bw_imm[idx]; in_base = bw_base[idx]; end
      @(negedge CLK);
      if (b_out_valid && b_out_ready) begin
        e = model(bw_ctrl[outn], bw_imm[outn], bw_base[outn]);
        chk("halt.out_instr", b_out_instr, e[31:0]);
        chk("halt.out_code", b_out_err_code, e[33:32]);
        outn++;
      end
      if (b_valid && b_in_ready) idx++;
      tick();
    end
  endtask

  initial begin
    int idx, outn;

    // Reset state
    @(posedge CLK); #1;
    chk("rst.out_valid", a_out_valid, 0);
    chk("rst.out_instr", a_out_instr, 0);
    chk("rst.out_err", a_out_err, 0);
    chk("rst.out_err_code", a_out_err_code, 0);
    chk("rst.err_count", a_err_count, 0);
    chk("rst.halted", b_halted, 0);
    Reset_L = 1'b1;
    tick();
    @(negedge CLK);
    chk("rst.in_ready_a", a_in_ready, 1);
    chk("rst.in_ready_b", b_in_ready, 1);
    tick();

    // Directed encodings
    send_a("i_max", 2'b00, 64'hFFF, 32'h91000000, 32'h913FFC00, 2'b00);
    send_a("i_range", 2'b00, 64'h1000, 32'h91000000, 32'h91000000, 2'b01);
    send_a("b_neg4", 2'b10, 64'hFFFF_FFFF_FFFF_FFFC, 32'h14000000, 32'h17FFFFFF, 2'b00);
    send_a("b_misal", 2'b10, 64'h6, 32'h14000000, 32'h14000000, 2'b10);
    send_a("d_256", 2'b01, 64'd256, 32'hF8400000, 32'hF8400000, 2'b01);
    send_a("d_m256", 2'b01, 64'hFFFF_FFFF_FFFF_FF00, 32'hF8400000, 32'hF8500000, 2'b00);
    send_a("cbz_8", 2'b11, 64'd8, 32'hB4000001, 32'hB4000041, 2'b00);
    send_a("b_both", 2'b10, 64'h0800_0002, 32'h14000000, 32'h14000000, 2'b11);
    send_a("d_255", 2'b01, 64'd255, 32'h0, 32'h000FF000, 2'b00);
    chk("cnt.after4", a_err_count, 4);
    for (int k = 0; k < 4; k++) send_a("i_sat", 2'b00, 64'h1000, 32'h0, 32'h0, 2'b01);
    chk("cnt.saturated", a_err_count, 7);

    // clear_err alone, then clear_err together with an error handshake
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    chk("cnt.cleared", a_err_count, 0);
    in_ctrl = 2'b01; in_imm = 64'd300; in_base = 32'h1; a_valid = 1'b1; a_out_ready = 1'b0;
    tick(); a_valid = 1'b0; tick();
    @(negedge CLK);
    chk("clr_hs.valid", a_out_valid, 1);
    tick();
    clear_err = 1'b1; a_out_ready = 1'b1;
    tick(); clear_err = 1'b0;
    chk("clr_hs.cnt", a_err_count, 1);

    // Back-to-back 8 words with out_ready toggling
    stream_a("toggle8", 8, 0, 100);

    // Halt-on-error: one error word followed by three good words
    bw_ctrl[0] = 2'b10; bw_imm[0] = 64'h6; bw_base[0] = 32'h14000000;
    for (int k = 1; k < 4; k++) begin
      bw_ctrl[k] = 2'b00; bw_imm[k] = 64'(k); bw_base[k] = 32'h91000000;
    end
    b_out_ready = 1'b1; idx = 0; outn = 0;
    run_b(10, idx, outn);
    chk("halt.halted", b_halted, 1);
    chk("halt.in_ready", b_in_ready, 0);
    chk("halt.err_count", b_err_count, 1);
    chk("halt.accepted", idx, 3);
    chk("halt.drained", outn, 3);
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    chk("halt.cleared", b_halted, 0);
    run_b(5, idx, outn);
    b_valid = 1'b0;
    chk("resume.accepted", idx, 4);
    chk("resume.out", outn, 4);
    chk("resume.err_count", b_err_count, 0);

    // Reset with two words in flight
    a_out_ready = 1'b0;
    in_ctrl = 2'b00; in_imm = 64'h1000; in_base = 32'h5; a_valid = 1'b1;
    tick();
    in_imm = 64'h2000;
    tick();
    a_valid = 1'b0;
    @(negedge CLK);
    chk("inflight.valid", a_out_valid, 1);
    #2 Reset_L = 1'b0;
    #1;
    chk("arst.out_valid", a_out_valid, 0);
    chk("arst.err_count", a_err_count, 0);
    chk("arst.out_instr", a_out_instr, 0);
    chk("arst.halted", b_halted, 0);
    @(negedge CLK); #1 Reset_L = 1'b1;
    a_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("arst.dropped", a_out_valid, 0);
    end
    chk("arst.in_ready", a_in_ready, 1);
    tick();

    // Randomized stream with random backpressure and round-trip checks
    stream_a("random", 3000, 1, 80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
